// File: rtl/lsu_ctrl.sv
// Load/store unit controller: byte/halfword/word MIPS loads and stores over a word-only
// memory port, using read-modify-write for sub-word stores and a per-access ack timeout.
module lsu_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_op;
   logic [31:0] r_addr;
   logic [15:0] r_wdata;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic [1:0]  r_err;
   logic [7:0]  r_cnt;

   logic        w_accept;
   logic        w_legal;
   logic        w_misalign;
   logic        w_in_mem;
   logic        w_timeout;
   logic        w_is_load;
   logic        w_is_half;
   logic        w_signed;
   logic [7:0]  w_lane_byte;
   logic [15:0] w_lane_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   // Low opcode nibble encodes the access: bit3 store, bit2 unsigned, bits1:0 size.
   assign w_accept  = start && (r_state == S_IDLE);
   assign w_in_mem  = (r_state == S_RD) || (r_state == S_WR);
   assign w_timeout = w_in_mem && !mem_ack && (r_cnt == 8'(TIMEOUT - 1));
   assign w_is_load = !r_op[3];
   assign w_is_half = (r_op[1:0] == 2'b01);
   assign w_signed  = !r_op[2];

   always_comb begin
      w_legal    = 1'b0;
      w_misalign = 1'b0;
      case (op)
         OP_LB, OP_LBU, OP_SB: w_legal = 1'b1;
         OP_LH, OP_LHU, OP_SH: begin
            w_legal    = 1'b1;
            w_misalign = addr[0];
         end
         OP_LW, OP_SW: begin
            w_legal    = 1'b1;
            w_misalign = |addr[1:0];
         end
         default: ;
      endcase
   end

   assign w_lane_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_lane_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load_data = mem_rdata;
      case (r_op[1:0])
         2'b00:   w_load_data = {{24{w_signed & w_lane_byte[7]}}, w_lane_byte};
         2'b01:   w_load_data = {{16{w_signed & w_lane_half[15]}}, w_lane_half};
         default: ;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic w_hit;
      assign w_hit = w_is_half ? (r_addr[1] == 1'(gi / 2)) : (r_addr[1:0] == 2'(gi));
      assign w_merged[8*gi +: 8] = !w_hit    ? mem_rdata[8*gi +: 8] :
                                   w_is_half ? r_wdata[8*(gi % 2) +: 8] : r_wdata[7:0];
   end

   always_ff @(posedge CLK) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_legal || w_misalign) w_state_next = S_DONE;
               else if (op == OP_SW)       w_state_next = S_WR;
               else                        w_state_next = S_RD;
            end
         end
         S_RD: begin
            if (mem_ack)        w_state_next = w_is_load ? S_DONE : S_WR;
            else if (w_timeout) w_state_next = S_DONE;
         end
         S_WR:    if (mem_ack || w_timeout) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (r_state != S_IDLE);
      done    = (r_state == S_DONE);
      mem_req = w_in_mem;
      mem_we  = (r_state == S_WR);
   end

   assign mem_addr  = {r_addr[31:2], 2'b00};
   assign mem_wdata = r_mem_wdata;
   assign rdata     = r_rdata;
   assign err       = r_err;

   always_ff @(posedge CLK) begin
      if (!reset) begin
         r_op        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_err       <= 2'b00;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= op[3:0];
            r_addr  <= addr;
            r_wdata <= wdata[15:0];
            if (!w_legal) begin
               r_err   <= 2'b10;
               r_rdata <= '0;
            end else if (w_misalign) begin
               r_err   <= 2'b01;
               r_rdata <= '0;
            end else begin
               r_err <= 2'b00;
               if (op == OP_SW) r_mem_wdata <= wdata;
            end
         end
         if ((r_state == S_RD) && mem_ack) begin
            if (w_is_load) r_rdata     <= w_load_data;
            else           r_mem_wdata <= w_merged;
         end else if (w_timeout) begin
            r_err   <= 2'b11;
            r_rdata <= '0;
         end
         // Counts no-ack cycles; any state change (including RD->WR) restarts it.
         if (w_in_mem && (w_state_next == r_state)) r_cnt <= r_cnt + 8'd1;
         else                                       r_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scoreboard of expected completions against a
// word memory model with configurable ack wait states.
module tb_lsu_ctrl;
   localparam int TO = 4;
   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
   localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  op = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        busy, done, mem_req, mem_we, mem_ack;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          req_age = 0;
   int          ack_wait = 0;
   logic        ack_force = 1'b0;
   logic [31:0] model_rdata = '0;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
      int          rd;
      int          wr;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } exp_t;
   exp_t sb_q[$];

   lsu_ctrl #(.TIMEOUT(TO)) dut (
      .CLK(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h10)      return 32'hDDCCBBAA;
      else if (a == 32'h20) return 32'h7F018000;
      else                  return 32'h0BADF00D;
   endfunction

   assign mem_rdata = word_at(mem_addr);
   assign mem_ack   = ack_force | (mem_req && (req_age >= ack_wait));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_req && !mem_ack) req_age <= req_age + 1;
      else                     req_age <= 0;
   end

   // Called at a negedge; returns at the negedge of the idle cycle after done.
   // For stores exp_data is the expected word on mem_wdata; for loads, the rdata.
   task automatic run_access(input string name, input logic [5:0] o, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_data,
                             input logic [1:0] exp_err, input int wait_n, input bit poke);
      exp_t        e;
      exp_t        g;
      int          t0;
      int          k = 0;
      int          rd_n = 0;
      int          wr_n = 0;
      int          lat;
      int          acc = wait_n + 1;
      logic [31:0] cap_addr = '0;
      logic [31:0] cap_wdata = '0;
      logic        seen;
      e.err    = exp_err;
      e.maddr  = {a[31:2], 2'b00};
      e.mwdata = exp_data;
      e.wr     = 0;
      if (exp_err == 2'b01 || exp_err == 2'b10) begin
         e.lat = 1; e.rd = 0; e.rdata = '0;
      end else if (exp_err == 2'b11) begin
         e.lat = 1 + TO; e.rd = TO; e.rdata = '0;
      end else if (!o[3]) begin
         e.lat = 1 + acc; e.rd = acc; e.rdata = exp_data;
      end else if (o[1:0] != 2'b11) begin
         e.lat = 1 + 2 * acc; e.rd = acc; e.wr = acc; e.rdata = model_rdata;
      end else begin
         e.lat = 1 + acc; e.rd = 0; e.wr = acc; e.rdata = model_rdata;
      end
      sb_q.push_back(e);
      ack_wait = wait_n;
      start = 1'b1; op = o; addr = a; wdata = wd; t0 = cyc;
      @(negedge clk);
      start = 1'b0; op = 6'($urandom); addr = $urandom; wdata = $urandom;
      while (!done && k < 40) begin
         if (mem_req && !mem_we) rd_n++;
         if (mem_req && mem_we) begin
            wr_n++;
            cap_wdata = mem_wdata;
         end
         if (mem_req) cap_addr = mem_addr;
         if (poke && k == 0) begin
            start = 1'b1; op = SB; addr = 32'h20; wdata = 32'hA5A5A5A5;
         end else if (poke && k == 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      seen = done;
      lat  = cyc - t0;
      g    = sb_q.pop_front();
      checks++;
      if (!seen) begin
         $display("FAIL %s done_seen: got no done within 40 cycles, required a done pulse", name);
         errors++;
      end
      checks++;
      if (lat !== g.lat) begin
         $display("FAIL %s latency: got %0d, required %0d", name, lat, g.lat);
         errors++;
      end
      checks++;
      if (rdata !== g.rdata) begin
         $display("FAIL %s rdata: got %h, required %h", name, rdata, g.rdata);
         errors++;
      end
      checks++;
      if (err !== g.err) begin
         $display("FAIL %s err: got %b, required %b", name, err, g.err);
         errors++;
      end
      checks++;
      if (rd_n !== g.rd || wr_n !== g.wr) begin
         $display("FAIL %s req_cycles: got rd=%0d wr=%0d, required rd=%0d wr=%0d",
                  name, rd_n, wr_n, g.rd, g.wr);
         errors++;
      end
      if (g.rd + g.wr > 0) begin
         checks++;
         if (cap_addr !== g.maddr) begin
            $display("FAIL %s mem_addr: got %h, required %h", name, cap_addr, g.maddr);
            errors++;
         end
      end
      if (g.wr > 0) begin
         checks++;
         if (cap_wdata !== g.mwdata) begin
            $display("FAIL %s mem_wdata: got %h, required %h", name, cap_wdata, g.mwdata);
            errors++;
         end
      end
      model_rdata = g.rdata;
      $display("txn %-16s op=%h addr=%h lat=%0d rdata=%h err=%b", name, o, a, lat, rdata, err);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL %s single_pulse: got done=%b busy=%b, required 0 0", name, done, busy);
         errors++;
      end
      ack_wait = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
         $display("FAIL reset_ctrl: got busy/done/req/we=%b, required 0000",
                  {busy, done, mem_req, mem_we});
         errors++;
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         $display("FAIL reset_mem: got addr=%h wdata=%h, required 0 0", mem_addr, mem_wdata);
         errors++;
      end
      checks++;
      if (rdata !== 32'h0 || err !== 2'b00) begin
         $display("FAIL reset_result: got rdata=%h err=%b, required 0 00", rdata, err);
         errors++;
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loads();
      run_access("lb_0x11",  LB,  32'h11, 32'h0, 32'hFFFFFFBB, 2'b00, 0, 1'b0);
      run_access("lbu_0x11", LBU, 32'h11, 32'h0, 32'h000000BB, 2'b00, 0, 1'b0);
      run_access("lh_0x12",  LH,  32'h12, 32'h0, 32'hFFFFDDCC, 2'b00, 0, 1'b0);
      run_access("lw_0x10",  LW,  32'h10, 32'h0, 32'hDDCCBBAA, 2'b00, 0, 1'b0);
      run_access("lhu_0x12", LHU, 32'h12, 32'h0, 32'h0000DDCC, 2'b00, 0, 1'b0);
      run_access("lb_0x13",  LB,  32'h13, 32'h0, 32'hFFFFFFDD, 2'b00, 0, 1'b0);
      run_access("lh_0x10",  LH,  32'h10, 32'h0, 32'hFFFFBBAA, 2'b00, 0, 1'b0);
      run_access("lbu_0x10", LBU, 32'h10, 32'h0, 32'h000000AA, 2'b00, 0, 1'b0);
      run_access("lb_0x21",  LB,  32'h21, 32'h0, 32'hFFFFFF80, 2'b00, 0, 1'b0);
      run_access("lh_0x22",  LH,  32'h22, 32'h0, 32'h00007F01, 2'b00, 0, 1'b0);
      run_access("lb_0x23",  LB,  32'h23, 32'h0, 32'h0000007F, 2'b00, 0, 1'b0);
      run_access("lhu_0x20", LHU, 32'h20, 32'h0, 32'h00008000, 2'b00, 0, 1'b0);
      run_access("lw_0x20_w2", LW, 32'h20, 32'h0, 32'h7F018000, 2'b00, 2, 1'b0);
   endtask

   task automatic test_stores();
      run_access("sb_0x12",    SB, 32'h12, 32'h12345655, 32'hDD55BBAA, 2'b00, 0, 1'b0);
      run_access("sh_0x12",    SH, 32'h12, 32'h0000BEEF, 32'hBEEFBBAA, 2'b00, 0, 1'b0);
      run_access("sb_0x21",    SB, 32'h21, 32'hFFFFFF11, 32'h7F011100, 2'b00, 0, 1'b0);
      run_access("sh_0x20",    SH, 32'h20, 32'h12345678, 32'h7F015678, 2'b00, 0, 1'b0);
      run_access("sb_0x13_w1", SB, 32'h13, 32'h000000EE, 32'hEECCBBAA, 2'b00, 1, 1'b0);
      run_access("sw_0x10",    SW, 32'h10, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 0, 1'b0);
      run_access("sw_0x14_w1", SW, 32'h14, 32'h01234567, 32'h01234567, 2'b00, 1, 1'b0);
   endtask

   task automatic test_errors();
      run_access("lw_0x06",  LW,    32'h06, 32'h0, 32'h0, 2'b01, 0, 1'b0);
      run_access("op_0x3F",  6'h3F, 32'h10, 32'h0, 32'h0, 2'b10, 0, 1'b0);
      run_access("sh_0x13",  SH,    32'h13, 32'h0, 32'h0, 2'b01, 0, 1'b0);
      run_access("lhu_0x11", LHU,   32'h11, 32'h0, 32'h0, 2'b01, 0, 1'b0);
      run_access("sw_0x12",  SW,    32'h12, 32'h0, 32'h0, 2'b01, 0, 1'b0);
      run_access("op_0x22",  6'h22, 32'h10, 32'h0, 32'h0, 2'b10, 0, 1'b0);
      run_access("lw_after_err", LW, 32'h10, 32'h0, 32'hDDCCBBAA, 2'b00, 0, 1'b0);
   endtask

   task automatic test_timeout();
      run_access("lw_timeout", LW, 32'h10, 32'h0, 32'h0, 2'b11, TO, 1'b0);
      checks++;
      if (err !== 2'b11 || rdata !== 32'h0) begin
         $display("FAIL timeout_hold: got err=%b rdata=%h, required 11 0", err, rdata);
         errors++;
      end
      run_access("lw_ack_last", LW, 32'h10, 32'h0, 32'hDDCCBBAA, 2'b00, TO - 1, 1'b0);
   endtask

   task automatic test_busy_start();
      run_access("lw_poked", LW, 32'h10, 32'h0, 32'hDDCCBBAA, 2'b00, 2, 1'b1);
      run_access("sb_poked", SB, 32'h12, 32'h12345655, 32'hDD55BBAA, 2'b00, 1, 1'b1);
   endtask

   task automatic test_ack_idle();
      ack_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({busy, done, mem_req} !== 3'b000) begin
            $display("FAIL ack_idle_%0d: got busy/done/req=%b, required 000", i,
                     {busy, done, mem_req});
            errors++;
         end
      end
      ack_force = 1'b0;
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      ack_wait = 20;
      start = 1'b1; op = LW; addr = 32'h10; wdata = 32'h0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (mem_req !== 1'b1) begin
         $display("FAIL abort_rd1: got mem_req=%b, required 1", mem_req);
         errors++;
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
         $display("FAIL abort_idle: got busy/done/req/we=%b, required 0000",
                  {busy, done, mem_req, mem_we});
         errors++;
      end
      checks++;
      if (rdata !== 32'h0 || err !== 2'b00 || mem_addr !== 32'h0) begin
         $display("FAIL abort_regs: got rdata=%h err=%b addr=%h, required 0 00 0",
                  rdata, err, mem_addr);
         errors++;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         $display("FAIL abort_no_done: got %0d done pulses, required 0", pulses);
         errors++;
      end
      ack_wait    = 0;
      model_rdata = '0;
      run_access("lb_after_reset", LB, 32'h11, 32'h0, 32'hFFFFFFBB, 2'b00, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_timeout();
      test_busy_start();
      test_ack_idle();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles mem_req stays high per access without mem_ack (legal range 2..255).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset sampled on rising CLK.
REQ-004 SHALL have port start, input, 1, request strobe; accepted only in IDLE.
REQ-005 SHALL have port op, input, 6, MIPS opcode: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw.
REQ-006 SHALL have port addr, input, 32, byte address (base + offset).
REQ-007 SHALL have port wdata, input, 32, store data (rt); sb/sh use its low byte/halfword.
REQ-008 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 32, extended load result.
REQ-011 SHALL have port err, output, 2: 00 ok, 01 misaligned, 10 illegal op, 11 timeout.
REQ-012 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32), mem_ack (in, 1), forming a word-wide memory port with no byte enables.

Function
REQ-013 SHALL capture op, addr and wdata on the cycle start is accepted; later input changes have no effect on that access.
REQ-014 SHALL implement states IDLE, RD, WR, DONE.
REQ-015 SHALL transition from IDLE on an accepted start as follows: illegal op -> DONE with err=10; misaligned (lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0) -> DONE with err=01; loads, sb, sh -> RD; sw -> WR.
REQ-016 SHALL hold mem_req=1, mem_we=0 in RD and mem_req=1, mem_we=1 in WR, with mem_addr={addr[31:2],2'b00}, stable until the state is left.
REQ-017 SHALL, in RD on mem_ack, go to DONE for loads, or go to WR for sb/sh after registering the merged word.
REQ-018 SHALL use little-endian byte lanes: byte n occupies bits 8n+7:8n and halfword h occupies bits 16h+15:16h.
REQ-019 SHALL sign-extend results for lb/lh and zero-extend for lbu/lhu; lw returns the word unchanged.
REQ-020 SHALL, for sb/sh, replace only the addressed lane of the read word with wdata's low byte/halfword (read-modify-write); for sw, drive mem_wdata=wdata.
REQ-021 SHALL go from WR to DONE on mem_ack.
REQ-022 SHALL clear a cycle counter on entry to RD/WR and increment it on each cycle without mem_ack; when TIMEOUT no-ack cycles have elapsed, it SHALL go to DONE with err=11 and mem_req low.
REQ-023 SHALL give mem_ack priority over timeout in the same cycle.
REQ-024 SHALL ignore mem_ack outside RD/WR.
REQ-025 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE.
REQ-026 SHALL ignore start while busy=1, and SHALL accept start in the IDLE cycle that immediately follows DONE.
REQ-027 SHALL update rdata only on a successful load; on error, rdata=0; on a store, rdata is unchanged.
REQ-028 SHALL hold err until the next accepted start, which clears it to 00.
REQ-029 SHALL meet the following latencies, with start in cycle T and zero-wait mem_ack: error done at T+1; load or sw done at T+2; sb/sh done at T+3.

Reset
REQ-030 SHALL, while reset=0 at a rising CLK edge, enter IDLE with busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, err=00 and the counter at 0.
REQ-031 SHALL abort any in-progress access on reset, with mem_req low from the following cycle and no done pulse generated.

Verification
REQ-032 SHALL verify loads from word 0x10=0xDDCCBBAA with immediate ack: lb 0x11 -> rdata 0xFFFFFFBB at T+2; lbu 0x11 -> 0x000000BB; lh 0x12 -> 0xFFFFDDCC; lw 0x10 -> 0xDDCCBBAA.
REQ-033 SHALL verify sb 0x12 with wdata 0x12345655 on word 0xDDCCBBAA -> RD then WR, mem_wdata 0xDD55BBAA, done at T+3.
REQ-034 SHALL verify lw 0x06 -> err=01 and done at T+1 with mem_req never asserted, and op 0x3F -> err=10 under the same conditions.
REQ-035 SHALL verify, with TIMEOUT=4 and mem_ack held 0 on a lw -> mem_req high exactly 4 cycles, then done with err=11 and rdata=0.
REQ-036 SHALL verify start pulsed during RD -> ignored, and the captured access completes unchanged.
REQ-037 SHALL verify reset=0 in the 2nd RD cycle -> IDLE next cycle, mem_req=0, no done pulse, and a fresh lb then succeeds.
